proc_control_unit: RTL and testbench

- Multi-cycle instruction sequencer that sits directly upstream of the 8-bit processor datapath (register file + ALU + write-source mux).
- Accepts one 8-bit instruction per run request and decodes it. Drives the datapath's Rx, Ry, AddSub, destSrc and regWrite controls for the required cycles, then signals completion.
- For move-immediate it waits on a valid handshake for the operand the datapath takes from its dataIn bus.

---
 rtl/proc_control_unit.sv | 117 +++++++++++
 tb/tb_proc_control_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// Multi-cycle sequencer for the 8-bit datapath.
// It decodes one instruction per run request, drives the register-file and ALU
// controls for the write cycle, and counts completed instructions.
module proc_control_unit #(
    parameter logic [2:0] ADD_CODE = 3'b000,
    parameter logic [2:0] SUB_CODE = 3'b001
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic [7:0] instr,
    input  logic       immValid,
    output logic [2:0] Rx,
    output logic [2:0] Ry,
    output logic [2:0] AddSub,
    output logic [1:0] destSrc,
    output logic       regWrite,
    output logic       immReq,
    output logic       busy,
    output logic       done,
    output logic [7:0] instrCount
);

    localparam logic [1:0] OpMv  = 2'b00;
    localparam logic [1:0] OpMvi = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpSub = 2'b11;

    localparam logic [1:0] SrcDataIn = 2'b00;
    localparam logic [1:0] SrcReg    = 2'b01;
    localparam logic [1:0] SrcAlu    = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StImm
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ir_q;
    logic [7:0] count_q;
    logic [1:0] opcode;
    logic       ir_load;

    assign opcode  = ir_q[7:6];
    // Requests arriving while busy are dropped, never queued.
    assign ir_load = (state_q == StIdle) && run;

    // State, instruction register and completion counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ir_q    <= 8'h00;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= instr;
            end
            if (regWrite) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Next-state and write-cycle controls.
    always_comb begin
        state_d  = state_q;
        regWrite = 1'b0;
        destSrc  = SrcDataIn;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (opcode)
                    OpMv: begin
                        destSrc  = SrcReg;
                        regWrite = 1'b1;
                        state_d  = StIdle;
                    end
                    OpMvi: begin
                        // Operand not yet requested; no write in this cycle.
                        destSrc = SrcDataIn;
                        state_d = StImm;
                    end
                    OpAdd, OpSub: begin
                        destSrc  = SrcAlu;
                        regWrite = 1'b1;
                        state_d  = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StImm: begin
                destSrc = SrcDataIn;
                // Waits indefinitely for the operand.
                if (immValid) begin
                    regWrite = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Rx         = ir_q[5:3];
    assign Ry         = ir_q[2:0];
    assign AddSub     = (opcode == OpSub) ? SUB_CODE : ADD_CODE;
    assign done       = regWrite;
    assign busy       = (state_q != StIdle);
    assign immReq     = (state_q == StImm);
    assign instrCount = count_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-age model.
module tb_proc_control_unit;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       immValid = 1'b0;
    logic [2:0] Rx, Ry, AddSub;
    logic [1:0] destSrc;
    logic       regWrite, immReq, busy, done;
    logic [7:0] instrCount;

    int errors = 0;
    int checks = 0;

    proc_control_unit #(
        .ADD_CODE(3'b000),
        .SUB_CODE(3'b001)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .instr     (instr),
        .immValid  (immValid),
        .Rx        (Rx),
        .Ry        (Ry),
        .AddSub    (AddSub),
        .destSrc   (destSrc),
        .regWrite  (regWrite),
        .immReq    (immReq),
        .busy      (busy),
        .done      (done),
        .instrCount(instrCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an accepted instruction and the number of edges since it
    // was accepted. Non-mvi writes one edge after acceptance; mvi writes at the
    // first edge at least two edges after acceptance that sees immValid.
    logic [7:0] m_ir;
    logic       m_pending;
    int         m_age;
    logic [7:0] m_count;

    function automatic logic m_write(input logic iv);
        if (!m_pending) return 1'b0;
        if (m_ir[7:6] != 2'b01) return (m_age == 1);
        return (m_age >= 2) && iv;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_ir      <= 8'h00;
            m_pending <= 1'b0;
            m_age     <= 0;
            m_count   <= 8'h00;
        end else if (m_pending) begin
            if (m_write(immValid)) begin
                m_pending <= 1'b0;
                m_count   <= m_count + 8'd1;
            end else if (m_age < 1000) begin
                m_age <= m_age + 1;
            end
        end else if (run) begin
            m_ir      <= instr;
            m_pending <= 1'b1;
            m_age     <= 1;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clock) begin
        logic [1:0] op;
        logic       w;
        logic [1:0] exp_src;
        op = m_ir[7:6];
        w  = m_write(immValid);
        if (!m_pending)      exp_src = 2'b00;
        else if (op == 2'b00) exp_src = 2'b01;
        else if (op == 2'b01) exp_src = 2'b00;
        else                  exp_src = 2'b10;
        check("m_Rx", {5'b0, Rx}, {5'b0, m_ir[5:3]});
        check("m_Ry", {5'b0, Ry}, {5'b0, m_ir[2:0]});
        check("m_AddSub", {5'b0, AddSub}, (op == 2'b11) ? 8'd1 : 8'd0);
        check("m_destSrc", {6'b0, destSrc}, {6'b0, exp_src});
        check("m_regWrite", {7'b0, regWrite}, {7'b0, w});
        check("m_done", {7'b0, done}, {7'b0, w});
        check("m_busy", {7'b0, busy}, {7'b0, m_pending});
        check("m_immReq", {7'b0, immReq}, {7'b0, m_pending && op == 2'b01 && m_age >= 2});
        check("m_instrCount", instrCount, m_count);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;

        // Reset held two cycles; outputs must sit at their reset values.
        resetn = 1'b0;
        step();
        step();
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_regWrite", {7'b0, regWrite}, 8'd0);
        check("rst_Rx", {5'b0, Rx}, 8'd0);
        check("rst_count", instrCount, 8'd0);
        resetn = 1'b1;

        // mv R2 <- R3
        run = 1'b1; instr = 8'b00_010_011;
        step();
        run = 1'b0; instr = 8'h00;
        check("mv_regWrite", {7'b0, regWrite}, 8'd1);
        check("mv_destSrc", {6'b0, destSrc}, 8'd1);
        check("mv_Rx", {5'b0, Rx}, 8'd2);
        check("mv_Ry", {5'b0, Ry}, 8'd3);
        check("mv_done", {7'b0, done}, 8'd1);
        step();
        check("mv_idle", {7'b0, busy}, 8'd0);
        check("mv_count", instrCount, 8'd1);

        // add then sub on R1, R2
        run = 1'b1; instr = 8'b10_001_010;
        step();
        run = 1'b0;
        check("add_AddSub", {5'b0, AddSub}, 8'd0);
        check("add_destSrc", {6'b0, destSrc}, 8'd2);
        check("add_write", {7'b0, regWrite}, 8'd1);
        step();
        run = 1'b1; instr = 8'b11_001_010;
        step();
        run = 1'b0;
        check("sub_AddSub", {5'b0, AddSub}, 8'd1);
        check("sub_write", {7'b0, regWrite}, 8'd1);
        step();
        check("sub_count", instrCount, 8'd3);

        // mvi R4 stalled four cycles; run held and instr changed while busy.
        run = 1'b1; instr = 8'b01_100_000;
        step();
        check("mvi_exec_write", {7'b0, regWrite}, 8'd0);
        instr = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mvi_immReq", {7'b0, immReq}, 8'd1);
            check("mvi_busy", {7'b0, busy}, 8'd1);
            check("mvi_nowrite", {7'b0, regWrite}, 8'd0);
            check("mvi_Rx_held", {5'b0, Rx}, 8'd4);
        end
        immValid = 1'b1;
        #1;
        check("mvi_write", {7'b0, regWrite}, 8'd1);
        check("mvi_destSrc", {6'b0, destSrc}, 8'd0);
        step();
        immValid = 1'b0;
        check("mvi_count", instrCount, 8'd4);
        // Next sampled instruction (FF: sub R7,R7) executes.
        step();
        run = 1'b0;
        check("post_Rx", {5'b0, Rx}, 8'd7);
        check("post_AddSub", {5'b0, AddSub}, 8'd1);
        step();

        // Asynchronous reset in the middle of an IMM wait.
        run = 1'b1; instr = 8'b01_101_001;
        step();
        run = 1'b0;
        step();
        step();
        check("imm_wait", {7'b0, immReq}, 8'd1);
        #2;
        immValid = 1'b1;
        resetn = 1'b0;
        #1;
        check("arst_immReq", {7'b0, immReq}, 8'd0);
        check("arst_busy", {7'b0, busy}, 8'd0);
        check("arst_regWrite", {7'b0, regWrite}, 8'd0);
        check("arst_count", instrCount, 8'd0);
        step();
        immValid = 1'b0;
        resetn = 1'b1;

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            run      = ($urandom_range(0, 1) == 1);
            instr    = 8'($urandom);
            immValid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) resetn = 1'b0;
            else resetn = 1'b1;
            step();
        end
        resetn = 1'b1; run = 1'b0; immValid = 1'b0;
        step();

        // 256 back-to-back mv instructions wrap the counter.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        run = 1'b1; instr = 8'b00_000_001;
        pulses = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            if (done) pulses++;
            step();
        end
        run = 1'b0;
        @(negedge clock);
        check("wrap_pulses", pulses[7:0] ^ 8'(pulses >> 8), 8'h01);
        check("wrap_count", instrCount, 8'h00);
        check("wrap_pulse_total", (pulses == 256) ? 8'd1 : 8'd0, 8'd1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
